// File: rtl/spi_master_pkg.sv
// Shared constants, state encoding and frame payload type for the SPI mode-0 initiator.
package spi_master_pkg;

    localparam int unsigned OP_BITS    = 2;
    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned FRAME_BITS = 10;

    localparam logic [OP_BITS-1:0] OP_WR_ADDR = 2'b00;
    localparam logic [OP_BITS-1:0] OP_WR_DATA = 2'b01;
    localparam logic [OP_BITS-1:0] OP_RD_ADDR = 2'b10;
    localparam logic [OP_BITS-1:0] OP_RD_DATA = 2'b11;

    localparam int unsigned ST_BITS = 3;
    localparam logic [ST_BITS-1:0] ST_IDLE     = 3'd0;
    localparam logic [ST_BITS-1:0] ST_SHIFT_TX = 3'd1;
    localparam logic [ST_BITS-1:0] ST_WAIT     = 3'd2;
    localparam logic [ST_BITS-1:0] ST_SHIFT_RX = 3'd3;
    localparam logic [ST_BITS-1:0] ST_GUARD    = 3'd4;

    // One serial frame: op in the top bits, shifted out MSB first.
    typedef struct packed {
        logic [OP_BITS-1:0]   op;
        logic [DATA_BITS-1:0] data;
    } spi_frame_t;

    function automatic logic is_read(input logic [OP_BITS-1:0] op);
        return op == OP_RD_DATA;
    endfunction

endpackage

// File: rtl/spi_master_if.sv
// Command/response port of the SPI initiator; host drives master, the initiator uses slave.
interface spi_master_if;
    import spi_master_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [OP_BITS-1:0]   cmd_op;
    logic [DATA_BITS-1:0] cmd_data;
    logic                 rsp_valid;
    logic [DATA_BITS-1:0] rsp_data;
    logic                 busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, busy
    );

endinterface

// File: rtl/spi_master_clk_gen.sv
// SCLK divider: toggles every HALF_DIV clks while enabled, parked low with count 0 otherwise.
module spi_clk_gen #(
    parameter int unsigned HALF_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise_pulse_c,
    output logic fall_pulse_c
);

    localparam int unsigned CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic          at_last_c;

    assign at_last_c = (cnt_q == LAST);

    // Pulses flag the clk edge on which sclk will toggle; independent of en so the
    // caller can veto the toggle by dropping en in the same cycle.
    assign rise_pulse_c = at_last_c && !sclk;
    assign fall_pulse_c = at_last_c &&  sclk;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt_q <= '0;
            sclk  <= 1'b0;
        end else if (at_last_c) begin
            cnt_q <= '0;
            sclk  <= ~sclk;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI mode-0 initiator: one SS_n-framed {op,data} transfer per command, plus 8-bit readback for op 11.
// Optional SPI_MASTER_LOOPBACK_EN adds lpbk_en, routing mosi into the receive path.
module spi_master
    import spi_master_pkg::*;
#(
    parameter int unsigned HALF_DIV  = 2,
    parameter int unsigned READ_WAIT = 2,
    parameter int unsigned CS_IDLE   = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    spi_master_if.slave  bus,
    output logic         sclk,
    output logic         ss_n,
    output logic         mosi,
    input  logic         miso
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic         lpbk_en
`endif
);

    localparam int unsigned CNT_W      = 16;
    localparam int unsigned GUARD_CLKS = CS_IDLE * 2 * HALF_DIV;

    logic [ST_BITS-1:0]    state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FRAME_BITS-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_BITS-1:0]  rx_sr_q, rx_sr_d;
    logic                  rd_q, rd_d;
    logic                  ss_n_d, mosi_d, ready_d, busy_d, rsp_valid_d;
    logic [DATA_BITS-1:0]  rsp_data_d;
    logic                  rise_c, fall_c, gen_en_c, rx_bit_c;
    spi_frame_t            frame_c;

`ifdef SPI_MASTER_LOOPBACK_EN
    assign rx_bit_c = lpbk_en ? mosi : miso;
`else
    assign rx_bit_c = miso;
`endif

    assign frame_c = '{op: bus.cmd_op, data: bus.cmd_data};

    spi_clk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (gen_en_c),
        .sclk         (sclk),
        .rise_pulse_c (rise_c),
        .fall_pulse_c (fall_c)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            tx_sr_q       <= '0;
            rx_sr_q       <= '0;
            rd_q          <= 1'b0;
            ss_n          <= 1'b1;
            mosi          <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tx_sr_q       <= tx_sr_d;
            rx_sr_q       <= rx_sr_d;
            rd_q          <= rd_d;
            ss_n          <= ss_n_d;
            mosi          <= mosi_d;
            bus.cmd_ready <= ready_d;
            bus.busy      <= busy_d;
            bus.rsp_valid <= rsp_valid_d;
            bus.rsp_data  <= rsp_data_d;
        end
    end

    // Next state and outputs. A period ends on the sclk rise that would start the next one,
    // so the frame closes one half-period after the last falling edge.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        rd_d        = rd_q;
        ss_n_d      = ss_n;
        mosi_d      = mosi;
        rsp_valid_d = 1'b0;
        rsp_data_d  = bus.rsp_data;
        gen_en_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    tx_sr_d = frame_c;
                    rd_d    = is_read(frame_c.op);
                    cnt_d   = '0;
                    ss_n_d  = 1'b0;
                    mosi_d  = frame_c.op[OP_BITS-1];
                    state_d = ST_SHIFT_TX;
                end
            end

            ST_SHIFT_TX: begin
                gen_en_c = 1'b1;
                if (fall_c) begin
                    mosi_d  = tx_sr_q[FRAME_BITS-2];
                    tx_sr_d = {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                end
                if (rise_c) begin
                    if (cnt_q == CNT_W'(FRAME_BITS)) begin
                        mosi_d = 1'b0;
                        if (!rd_q) begin
                            gen_en_c = 1'b0;
                            ss_n_d   = 1'b1;
                            cnt_d    = '0;
                            state_d  = (GUARD_CLKS == 0) ? ST_IDLE : ST_GUARD;
                        end else if (READ_WAIT == 0) begin
                            rx_sr_d = {rx_sr_q[DATA_BITS-2:0], rx_bit_c};
                            cnt_d   = CNT_W'(1);
                            state_d = ST_SHIFT_RX;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_WAIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_WAIT: begin
                gen_en_c = 1'b1;
                mosi_d   = 1'b0;
                if (rise_c) begin
                    if (cnt_q == CNT_W'(READ_WAIT)) begin
                        rx_sr_d = {rx_sr_q[DATA_BITS-2:0], rx_bit_c};
                        cnt_d   = CNT_W'(1);
                        state_d = ST_SHIFT_RX;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_SHIFT_RX: begin
                gen_en_c = 1'b1;
                mosi_d   = 1'b0;
                if (rise_c) begin
                    if (cnt_q == CNT_W'(DATA_BITS)) begin
                        gen_en_c    = 1'b0;
                        ss_n_d      = 1'b1;
                        rsp_data_d  = rx_sr_q;
                        rsp_valid_d = 1'b1;
                        cnt_d       = '0;
                        state_d     = (GUARD_CLKS == 0) ? ST_IDLE : ST_GUARD;
                    end else begin
                        rx_sr_d = {rx_sr_q[DATA_BITS-2:0], rx_bit_c};
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end

            ST_GUARD: begin
                if (cnt_q == CNT_W'(GUARD_CLKS - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                ss_n_d  = 1'b1;
                mosi_d  = 1'b0;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = !ready_d;
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave/RAM on the pins.
module tb_spi_master;
    import spi_master_pkg::*;

    localparam int HALF_DIV  = 2;
    localparam int READ_WAIT = 2;
    localparam int CS_IDLE   = 1;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic tie_one = 1'b0;
    logic miso_s  = 1'b0;
    logic sclk, ss_n, mosi, miso;
`ifdef SPI_MASTER_LOOPBACK_EN
    logic lpbk_en = 1'b0;
`endif

    spi_master_if bus();

    always #5 clk = ~clk;
    assign miso = tie_one ? 1'b1 : miso_s;

    spi_master #(
        .HALF_DIV  (HALF_DIV),
        .READ_WAIT (READ_WAIT),
        .CS_IDLE   (CS_IDLE)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .sclk  (sclk),
        .ss_n  (ss_n),
        .mosi  (mosi),
        .miso  (miso)
`ifdef SPI_MASTER_LOOPBACK_EN
        ,
        .lpbk_en (lpbk_en)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Slave/RAM model: 10-bit frame on sclk rises; read byte driven on falls after READ_WAIT periods.
    logic [7:0] mem [256] = '{default: 8'h00};
    logic [7:0] s_addr = 8'h00;
    logic [9:0] s_sr   = 10'h0;
    logic [7:0] s_byte = 8'h00;
    logic       s_rd   = 1'b0;
    int         s_bits = 0;
    int         s_fidx = 0;
    logic [9:0] s_log[$];

    always @(posedge sclk or posedge ss_n) begin
        if (ss_n === 1'b1) begin
            s_bits = 0;
            s_rd   = 1'b0;
        end else if (ss_n === 1'b0 && s_bits < 10) begin
            s_sr = {s_sr[8:0], mosi};
            s_bits++;
            if (s_bits == 10) begin
                s_log.push_back(s_sr);
                case (s_sr[9:8])
                    2'b00, 2'b10: s_addr = s_sr[7:0];
                    2'b01:        mem[s_addr] = s_sr[7:0];
                    default: begin
                        s_byte = mem[s_addr];
                        s_rd   = 1'b1;
                    end
                endcase
            end
        end
    end

    always @(negedge sclk or posedge ss_n) begin
        if (ss_n === 1'b1) begin
            s_fidx = 0;
            miso_s = 1'b0;
        end else if (s_rd) begin
            s_fidx++;
            if (s_fidx >= READ_WAIT + 1 && s_fidx <= READ_WAIT + 8)
                miso_s = s_byte[READ_WAIT + 8 - s_fidx];
        end
    end

    // Pin monitors.
    int rises = 0, rsp_cnt = 0, low_run = 0, last_low = 0, hi_run = 0, min_gap = 100000, busy_bad = 0;

    always @(posedge sclk) if (ss_n === 1'b0) rises++;

    always @(negedge clk) begin
        if (bus.rsp_valid === 1'b1) rsp_cnt++;
        if (ss_n === 1'b0) begin
            if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
            low_run++;
            if (bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) busy_bad++;
        end else begin
            if (low_run > 0) last_low = low_run;
            low_run = 0;
            hi_run++;
        end
    end

    task automatic send(input logic [1:0] op, input logic [7:0] d);
        bit acc = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = d;
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = bus.cmd_ready;
            @(negedge clk);
        end
        if (!acc) check_eq("accept_timeout", {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic idle_wait();
        bit done = 1'b0;
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            done = bus.cmd_ready && ss_n;
        end
        if (!done) check_eq("idle_timeout", {31'b0, bus.cmd_ready}, 32'd1);
    endtask

    int r0, p0, n0;

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_eq("rst_ss_n",      {31'b0, ss_n},          32'd1);
        check_eq("rst_sclk",      {31'b0, sclk},          32'd0);
        check_eq("rst_mosi",      {31'b0, mosi},          32'd0);
        check_eq("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check_eq("rst_busy",      {31'b0, bus.busy},      32'd0);
        check_eq("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check_eq("rst_rsp_data",  {24'b0, bus.rsp_data},  32'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write address A5: bits, pulse count, frame length.
        r0 = rises; p0 = rsp_cnt; n0 = s_log.size();
        send(OP_WR_ADDR, 8'hA5);
        idle_wait();
        check_eq("t1_frames", 32'(s_log.size() - n0), 32'd1);
        if (s_log.size() > n0) check_eq("t1_bits", {22'b0, s_log[n0]}, 32'h0A5);
        check_eq("t1_rises",  32'(rises - r0),   32'd10);
        check_eq("t1_rsp",    32'(rsp_cnt - p0), 32'd0);
        check_eq("t1_ss_low", 32'(last_low),     32'd42);

        // Write 3C to 0x10 and read it back, back-to-back.
        p0 = rsp_cnt;
        send(OP_WR_ADDR, 8'h10);
        send(OP_WR_DATA, 8'h3C);
        send(OP_RD_ADDR, 8'h10);
        send(OP_RD_DATA, 8'h00);
        idle_wait();
        check_eq("t2_rsp_cnt",  32'(rsp_cnt - p0),       32'd1);
        check_eq("t2_rsp_data", {24'b0, bus.rsp_data},   32'h3C);
        check_eq("t3_rd_low",   32'(last_low),           32'd82);
        check_eq("t3_gap_ge4",  {31'b0, min_gap >= 4},   32'd1);

        // Held valid across three commands, then read the written byte.
        n0 = s_log.size();
        send(OP_WR_ADDR, 8'h20);
        send(OP_WR_DATA, 8'h5A);
        send(OP_WR_ADDR, 8'h21);
        idle_wait();
        check_eq("t4_frames", 32'(s_log.size() - n0), 32'd3);
        if (s_log.size() >= n0 + 3) begin
            check_eq("t4_f0", {22'b0, s_log[n0]},     32'h020);
            check_eq("t4_f1", {22'b0, s_log[n0 + 1]}, 32'h15A);
            check_eq("t4_f2", {22'b0, s_log[n0 + 2]}, 32'h021);
        end
        p0 = rsp_cnt;
        send(OP_RD_ADDR, 8'h20);
        send(OP_RD_DATA, 8'hFF);
        idle_wait();
        check_eq("t4_rd_data", {24'b0, bus.rsp_data}, 32'h5A);
        check_eq("t4_rd_cnt",  32'(rsp_cnt - p0),     32'd1);
        check_eq("t4_busy",    32'(busy_bad),         32'd0);
        check_eq("t4_gap_ge4", {31'b0, min_gap >= 4}, 32'd1);

        // Reset on the 5th receive bit.
        r0 = rises; p0 = rsp_cnt;
        send(OP_RD_DATA, 8'h00);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 200 && (rises - r0) < 17; i++) @(negedge clk);
        if ((rises - r0) < 17) check_eq("t5_rise_timeout", 32'(rises - r0), 32'd17);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("t5_ss_n",      {31'b0, ss_n},          32'd1);
        check_eq("t5_sclk",      {31'b0, sclk},          32'd0);
        check_eq("t5_cmd_ready", {31'b0, bus.cmd_ready}, 32'd1);
        check_eq("t5_busy",      {31'b0, bus.busy},      32'd0);
        check_eq("t5_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        check_eq("t5_rsp_data",  {24'b0, bus.rsp_data},  32'h00);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check_eq("t5_no_rsp", 32'(rsp_cnt - p0), 32'd0);

        // miso tied high: read returns FF; with loopback it returns the zeros on mosi.
        tie_one = 1'b1;
        send(OP_RD_DATA, 8'h00);
        idle_wait();
        check_eq("t6_miso_ff", {24'b0, bus.rsp_data}, 32'hFF);
`ifdef SPI_MASTER_LOOPBACK_EN
        lpbk_en = 1'b1;
        send(OP_RD_DATA, 8'h00);
        idle_wait();
        check_eq("t6_lpbk_00", {24'b0, bus.rsp_data}, 32'h00);
        lpbk_en = 1'b0;
        send(OP_RD_DATA, 8'h00);
        idle_wait();
        check_eq("t6_nolpbk_ff", {24'b0, bus.rsp_data}, 32'hFF);
`endif
        tie_one = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
